cpe_mem_arb: RTL and testbench

Single-port memory arbiter and bus sequencer for the RV32I core. It shares one external memory port between two requesters: the instruction-fetch path and the load/store path. It runs one transaction at a time with a req/gnt/valid handshake and waits for memory wait-states with an ack. A watchdog aborts any transaction that hangs, so the core never deadlocks on a dead slave.

---
 rtl/cpe_mem_arb.sv | 170 +++++++++++++++++
 tb/tb_cpe_mem_arb.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpe_mem_arb.sv
// cpe_mem_arb: single-port memory arbiter and bus sequencer for the RV32I core.
//
// Shares one external memory port between the instruction-fetch (IF) path and the
// load/store (LS) path. It runs one transaction at a time:
//   IDLE -> grant a requester, register the request fields
//   BUSY -> drive the read or write strobe until mem_ack_w_i_h or watchdog expiry
//   DONE -> pulse the owner's valid (and err on watchdog abort), then back to IDLE
// Under contention the arbiter alternates between the two requesters, so neither starves.
//
// Ports:
//   clk_w_i, res_w_i_l       clock, asynchronous active-low reset
//   if_req/if_addr           fetch request and address
//   if_gnt/if_rdata/if_valid fetch grant pulse, read data, completion pulse
//   ls_req/we/addr/wdata/be  load/store request fields
//   ls_gnt/ls_rdata/ls_valid load/store grant pulse, load data, completion pulse
//   mem_addr/wdata/be        registered memory request fields
//   mem_wr/mem_rd            write/read strobes, high for the whole BUSY phase
//   mem_rdata/mem_ack        memory read data and completion
//   err_w_o_h                watchdog abort, coincident with the owner's valid
module cpe_mem_arb #(
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic        clk_w_i,
    input  logic        res_w_i_l,
    input  logic        if_req_w_i_h,
    input  logic [31:0] if_addr_w_i,
    output logic        if_gnt_w_o_h,
    output logic [31:0] if_rdata_w_o,
    output logic        if_valid_w_o_h,
    input  logic        ls_req_w_i_h,
    input  logic        ls_we_w_i_h,
    input  logic [31:0] ls_addr_w_i,
    input  logic [31:0] ls_wdata_w_i,
    input  logic [3:0]  ls_be_w_i,
    output logic        ls_gnt_w_o_h,
    output logic [31:0] ls_rdata_w_o,
    output logic        ls_valid_w_o_h,
    output logic [31:0] mem_addr_w_o,
    output logic [31:0] mem_wdata_w_o,
    output logic [3:0]  mem_be_w_o,
    output logic        mem_wr_w_o_h,
    output logic        mem_rd_w_o_h,
    input  logic [31:0] mem_rdata_w_i,
    input  logic        mem_ack_w_i_h,
    output logic        err_w_o_h
);

    localparam int unsigned CntW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
    // Counter value during the last permitted BUSY cycle (counter is 0 in the first one).
    localparam logic [CntW-1:0] WdLast = (TIMEOUT_CYC == 0) ? '0 : CntW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } state_e;

    state_e          state_q;
    logic            owner_q;      // 0 = IF, 1 = LS
    logic            last_q;       // last winner, 0 = IF, 1 = LS
    logic            we_q;
    logic [CntW-1:0] wd_cnt_q;
    logic [31:0]     mem_addr_q;
    logic [31:0]     mem_wdata_q;
    logic [3:0]      mem_be_q;
    logic            mem_rd_q;
    logic            mem_wr_q;
    logic [31:0]     if_rdata_q;
    logic [31:0]     ls_rdata_q;
    logic            if_valid_q;
    logic            ls_valid_q;
    logic            err_q;

    logic            idle;
    logic            if_win;
    logic            ls_win;
    logic            ls_store;
    logic            wd_expire;

    // LS wins a tie unless it won last time, giving round-robin under contention.
    always_comb begin
        idle      = (state_q == StIdle);
        ls_win    = ls_req_w_i_h & (~if_req_w_i_h | ~last_q);
        if_win    = if_req_w_i_h & ~ls_win;
        ls_store  = ls_win & ls_we_w_i_h;
        wd_expire = (TIMEOUT_CYC != 0) && (wd_cnt_q == WdLast);
    end

    always_ff @(posedge clk_w_i or negedge res_w_i_l) begin
        if (!res_w_i_l) begin
            state_q     <= StIdle;
            owner_q     <= 1'b0;
            last_q      <= 1'b0;
            we_q        <= 1'b0;
            wd_cnt_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            if_rdata_q  <= '0;
            ls_rdata_q  <= '0;
            if_valid_q  <= 1'b0;
            ls_valid_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (if_win || ls_win) begin
                        owner_q     <= ls_win;
                        last_q      <= ls_win;
                        we_q        <= ls_store;
                        mem_addr_q  <= ls_win ? ls_addr_w_i : if_addr_w_i;
                        mem_wdata_q <= ls_win ? ls_wdata_w_i : 32'h0;
                        mem_be_q    <= ls_win ? ls_be_w_i : 4'hF;
                        mem_rd_q    <= ~ls_store;
                        mem_wr_q    <= ls_store;
                        wd_cnt_q    <= '0;
                        state_q     <= StBusy;
                    end
                end
                StBusy: begin
                    if (mem_ack_w_i_h || wd_expire) begin
                        // Ack has priority over a same-cycle watchdog expiry.
                        if (!we_q) begin
                            if (owner_q) begin
                                ls_rdata_q <= mem_ack_w_i_h ? mem_rdata_w_i : 32'h0;
                            end else begin
                                if_rdata_q <= mem_ack_w_i_h ? mem_rdata_w_i : 32'h0;
                            end
                        end
                        err_q      <= ~mem_ack_w_i_h;
                        mem_rd_q   <= 1'b0;
                        mem_wr_q   <= 1'b0;
                        if_valid_q <= ~owner_q;
                        ls_valid_q <= owner_q;
                        state_q    <= StDone;
                    end else begin
                        wd_cnt_q <= wd_cnt_q + CntW'(1);
                    end
                end
                StDone: begin
                    if_valid_q <= 1'b0;
                    ls_valid_q <= 1'b0;
                    err_q      <= 1'b0;
                    state_q    <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    always_comb begin
        if_gnt_w_o_h   = idle & if_win;
        ls_gnt_w_o_h   = idle & ls_win;
        if_rdata_w_o   = if_rdata_q;
        ls_rdata_w_o   = ls_rdata_q;
        if_valid_w_o_h = if_valid_q;
        ls_valid_w_o_h = ls_valid_q;
        mem_addr_w_o   = mem_addr_q;
        mem_wdata_w_o  = mem_wdata_q;
        mem_be_w_o     = mem_be_q;
        mem_rd_w_o_h   = mem_rd_q;
        mem_wr_w_o_h   = mem_wr_q;
        err_w_o_h      = err_q;
    end

endmodule

// File: tb/tb_cpe_mem_arb.sv
// Self-checking bench for cpe_mem_arb: directed scenarios followed by a randomized run
// checked against a transaction-level reference model.
module tb_cpe_mem_arb;

    localparam int unsigned TO = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req, ls_req, ls_we, mem_ack;
    logic [31:0] if_addr, ls_addr, ls_wdata, mem_rdata;
    logic [3:0]  ls_be;
    logic        if_gnt, if_valid, ls_gnt, ls_valid, mem_wr, mem_rd, err;
    logic [31:0] if_rdata, ls_rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_be;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cpe_mem_arb #(.TIMEOUT_CYC(TO)) dut (
        .clk_w_i        (clk),
        .res_w_i_l      (rst_n),
        .if_req_w_i_h   (if_req),
        .if_addr_w_i    (if_addr),
        .if_gnt_w_o_h   (if_gnt),
        .if_rdata_w_o   (if_rdata),
        .if_valid_w_o_h (if_valid),
        .ls_req_w_i_h   (ls_req),
        .ls_we_w_i_h    (ls_we),
        .ls_addr_w_i    (ls_addr),
        .ls_wdata_w_i   (ls_wdata),
        .ls_be_w_i      (ls_be),
        .ls_gnt_w_o_h   (ls_gnt),
        .ls_rdata_w_o   (ls_rdata),
        .ls_valid_w_o_h (ls_valid),
        .mem_addr_w_o   (mem_addr),
        .mem_wdata_w_o  (mem_wdata),
        .mem_be_w_o     (mem_be),
        .mem_wr_w_o_h   (mem_wr),
        .mem_rd_w_o_h   (mem_rd),
        .mem_rdata_w_i  (mem_rdata),
        .mem_ack_w_i_h  (mem_ack),
        .err_w_o_h      (err)
    );

    task automatic idle_inputs();
        if_req = 0; ls_req = 0; ls_we = 0; mem_ack = 0;
        if_addr = 0; ls_addr = 0; ls_wdata = 0; ls_be = 0; mem_rdata = 0;
    endtask

    // Leaves the bench at a falling edge with reset released.
    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
    endtask

    // Unchecked zero-wait fetch used to preload if_rdata.
    task automatic fetch_once(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk); if_req = 1; if_addr = a;
        @(negedge clk); if_req = 0; mem_ack = 1; mem_rdata = d;
        @(negedge clk); mem_ack = 0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [167:0] outs;
        do_reset();
        if_req = 1; if_addr = 32'h40;
        #1;
        checks++;
        if (if_gnt !== 1'b1) begin
            errors++; $display("FAIL reset_pre_gnt: if_gnt=%b want 1", if_gnt);
        end
        @(negedge clk); if_req = 0;
        #1;
        checks++;
        if (mem_rd !== 1'b1) begin
            errors++; $display("FAIL reset_pre_rd: mem_rd=%b want 1", mem_rd);
        end
        #1 rst_n = 0;
        #1;
        outs = {if_gnt, ls_gnt, if_valid, ls_valid, mem_rd, mem_wr, err, mem_be,
                mem_addr, mem_wdata, if_rdata, ls_rdata, 1'b0};
        checks++;
        if (mem_rd !== 1'b0 || mem_wr !== 1'b0) begin
            errors++; $display("FAIL reset_strobe_drop: rd=%b wr=%b want 0 0", mem_rd, mem_wr);
        end
        checks++;
        if (outs !== '0) begin
            errors++; $display("FAIL reset_outputs: got %h want 0", outs);
        end
        @(negedge clk); rst_n = 1; mem_ack = 1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if ({if_valid, ls_valid, err, mem_rd, mem_wr, if_gnt, ls_gnt} !== 7'b0) begin
                errors++;
                $display("FAIL reset_no_valid: v=%b%b err=%b rd=%b wr=%b want all 0",
                         if_valid, ls_valid, err, mem_rd, mem_wr);
            end
            @(negedge clk);
        end
        mem_ack = 0;
    endtask

    task automatic test_fetch_zero_wait();
        do_reset();
        if_req = 1; if_addr = 32'h0000_0100;
        #1;
        checks++;
        if ({if_gnt, ls_gnt} !== 2'b10) begin
            errors++; $display("FAIL fetch_gnt: gnt=%b%b want 10", if_gnt, ls_gnt);
        end
        @(negedge clk); if_req = 0;
        #1;
        checks++;
        if ({mem_rd, mem_wr, mem_be, mem_addr} !== {1'b1, 1'b0, 4'hF, 32'h0000_0100}) begin
            errors++;
            $display("FAIL fetch_strobe: rd=%b wr=%b be=%h addr=%h want 1 0 f 00000100",
                     mem_rd, mem_wr, mem_be, mem_addr);
        end
        mem_ack = 1; mem_rdata = 32'h0010_0093;
        @(negedge clk); mem_ack = 0; mem_rdata = 32'h1111_2222;
        #1;
        checks++;
        if ({if_valid, ls_valid, err, mem_rd, if_rdata} !== {4'b1000, 32'h0010_0093}) begin
            errors++;
            $display("FAIL fetch_valid: v=%b%b err=%b rd=%b rdata=%h want 1 0 0 0 00100093",
                     if_valid, ls_valid, err, mem_rd, if_rdata);
        end
        @(negedge clk);
        #1;
        checks++;
        if (if_valid !== 1'b0 || if_rdata !== 32'h0010_0093) begin
            errors++;
            $display("FAIL fetch_hold: v=%b rdata=%h want 0 00100093", if_valid, if_rdata);
        end
    endtask

    task automatic test_store_wait();
        int pulses = 0;
        do_reset();
        ls_req = 1; ls_we = 1; ls_addr = 32'h0000_2004; ls_wdata = 32'hCAFE_F00D;
        ls_be = 4'b0011;
        #1;
        checks++;
        if ({if_gnt, ls_gnt} !== 2'b01) begin
            errors++; $display("FAIL store_gnt: gnt=%b%b want 01", if_gnt, ls_gnt);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            ls_req = 0; ls_we = 0; ls_addr = 0; ls_wdata = 0; ls_be = 0;
            mem_ack = (i == 3); mem_rdata = 32'hDEAD_BEEF;
            #1;
            checks++;
            if ({mem_wr, mem_rd, ls_valid, mem_addr, mem_wdata, mem_be} !==
                {3'b100, 32'h0000_2004, 32'hCAFE_F00D, 4'b0011}) begin
                errors++;
                $display("FAIL store_busy%0d: wr=%b rd=%b v=%b a=%h d=%h be=%h", i,
                         mem_wr, mem_rd, ls_valid, mem_addr, mem_wdata, mem_be);
            end
        end
        @(negedge clk); mem_ack = 0;
        #1;
        checks++;
        if ({ls_valid, if_valid, err, mem_wr, ls_rdata} !== {4'b1000, 32'h0}) begin
            errors++;
            $display("FAIL store_valid: v=%b ifv=%b err=%b wr=%b rdata=%h want 1 0 0 0 0",
                     ls_valid, if_valid, err, mem_wr, ls_rdata);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            if (ls_valid) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++; $display("FAIL store_single_valid: extra pulses=%0d want 0", pulses);
        end
    endtask

    task automatic test_contention();
        int n = 0;
        int last_t = -1;
        do_reset();
        if_req = 1; if_addr = 32'h100; ls_req = 1; ls_we = 0; ls_addr = 32'h200;
        mem_ack = 1;
        for (int c = 0; c < 30 && n < 4; c++) begin
            #1;
            checks++;
            if ((if_gnt && ls_gnt) || ((if_gnt || ls_gnt) && (if_valid || ls_valid))) begin
                errors++;
                $display("FAIL cont_gnt_legal: gnt=%b%b valid=%b%b", if_gnt, ls_gnt,
                         if_valid, ls_valid);
            end
            if (if_gnt || ls_gnt) begin
                checks++;
                if (ls_gnt !== ((n % 2) == 0)) begin
                    errors++;
                    $display("FAIL cont_order%0d: ls_gnt=%b want %b", n, ls_gnt, (n % 2) == 0);
                end
                if (last_t >= 0) begin
                    checks++;
                    if (c - last_t != 3) begin
                        errors++; $display("FAIL cont_gap: gap=%0d want 3", c - last_t);
                    end
                end
                last_t = c;
                n++;
            end
            @(negedge clk);
        end
        checks++;
        if (n != 4) begin
            errors++; $display("FAIL cont_count: grants=%0d want 4", n);
        end
        idle_inputs();
        @(negedge clk); @(negedge clk); @(negedge clk);
    endtask

    task automatic test_timeout();
        int rd_cnt = 0;
        bit seen = 0;
        do_reset();
        fetch_once(32'h10, 32'h1234_5678);
        if_req = 1; if_addr = 32'h0000_0300;
        #1;
        checks++;
        if (if_gnt !== 1'b1) begin
            errors++; $display("FAIL to_gnt: if_gnt=%b want 1", if_gnt);
        end
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge clk); if_req = 0;
            #1;
            if (if_valid) begin
                seen = 1;
                checks++;
                if (rd_cnt != TO || err !== 1'b1 || if_rdata !== 32'h0 || mem_rd !== 1'b0) begin
                    errors++;
                    $display("FAIL to_abort: rd_cycles=%0d err=%b rdata=%h rd=%b want %0d 1 0 0",
                             rd_cnt, err, if_rdata, mem_rd, TO);
                end
            end else if (mem_rd) begin
                rd_cnt++;
            end
        end
        checks++;
        if (!seen) begin
            errors++; $display("FAIL to_no_valid: no valid within 40 cycles");
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); mem_ack = 1; mem_rdata = 32'h7777_8888;
            #1;
            checks++;
            if ({if_valid, ls_valid, err, mem_rd, mem_wr, if_rdata} !== {5'b0, 32'h0}) begin
                errors++;
                $display("FAIL to_late_ack: v=%b%b err=%b rd=%b rdata=%h want 0 0 0 0 0",
                         if_valid, ls_valid, err, mem_rd, if_rdata);
            end
        end
        mem_ack = 0;
    endtask

    task automatic test_collision();
        int rd_cnt = 0;
        do_reset();
        ls_req = 1; ls_we = 0; ls_addr = 32'h0000_0444; ls_be = 4'h1;
        #1;
        checks++;
        if (ls_gnt !== 1'b1) begin
            errors++; $display("FAIL coll_gnt: ls_gnt=%b want 1", ls_gnt);
        end
        for (int n = 1; n <= TO; n++) begin
            @(negedge clk); ls_req = 0;
            mem_ack = (n == TO); mem_rdata = 32'hA5A5_5A5A;
            #1;
            if (mem_rd) rd_cnt++;
        end
        @(negedge clk); mem_ack = 0;
        #1;
        checks++;
        if ({ls_valid, err, ls_rdata} !== {2'b10, 32'hA5A5_5A5A} || rd_cnt != TO) begin
            errors++;
            $display("FAIL coll_result: v=%b err=%b rdata=%h rd_cycles=%0d want 1 0 a5a55a5a %0d",
                     ls_valid, err, ls_rdata, rd_cnt, TO);
        end
    endtask

    // Transaction-level model: phase 0 idle, 1 busy, 2 done.
    task automatic test_random();
        bit          if_pend = 0, ls_pend = 0, ls_w = 0;
        logic [31:0] if_a = 0, ls_a = 0, ls_d = 0;
        logic [3:0]  ls_b = 0;
        int          phase = 0, busy_n = 0, ack_at = 0, done_cnt = 0;
        bit          own_ls = 0, last_ls = 0, m_we = 0, m_err = 0, w_if, w_ls, idle_m;
        logic [31:0] e_addr = 0, e_wdata = 0, e_ifr = 0, e_lsr = 0;
        logic [3:0]  e_be = 0;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (!if_pend && $urandom_range(0, 3) == 0) begin
                if_pend = 1; if_a = $urandom;
            end
            if (!ls_pend && $urandom_range(0, 3) == 0) begin
                ls_pend = 1; ls_a = $urandom; ls_d = $urandom; ls_b = 4'($urandom);
                ls_w = 1'($urandom);
            end
            if_req = if_pend; if_addr = if_a;
            ls_req = ls_pend; ls_we = ls_w; ls_addr = ls_a; ls_wdata = ls_d; ls_be = ls_b;
            mem_rdata = $urandom;
            mem_ack = (phase == 1) ? (busy_n == ack_at) : ($urandom_range(0, 3) == 0);
            #1;
            idle_m = (phase == 0);
            w_ls = ls_pend && (!if_pend || !last_ls);
            w_if = if_pend && !w_ls;
            checks++;
            if ({if_gnt, ls_gnt} !== {idle_m && w_if, idle_m && w_ls}) begin
                errors++;
                $display("FAIL rnd_gnt c=%0d: gnt=%b%b want %b%b", c, if_gnt, ls_gnt,
                         idle_m && w_if, idle_m && w_ls);
            end
            checks++;
            if ({mem_rd, mem_wr} !== ((phase == 1) ? {!m_we, m_we} : 2'b00)) begin
                errors++;
                $display("FAIL rnd_strobe c=%0d: rd=%b wr=%b phase=%0d we=%b", c, mem_rd,
                         mem_wr, phase, m_we);
            end
            checks++;
            if ({if_valid, ls_valid, err} !== ((phase == 2) ? {!own_ls, own_ls, m_err} : 3'b0))
            begin
                errors++;
                $display("FAIL rnd_valid c=%0d: v=%b%b err=%b phase=%0d own_ls=%b err_exp=%b",
                         c, if_valid, ls_valid, err, phase, own_ls, m_err);
            end
            checks++;
            if ({mem_addr, mem_wdata, mem_be, if_rdata, ls_rdata} !==
                {e_addr, e_wdata, e_be, e_ifr, e_lsr}) begin
                errors++;
                $display("FAIL rnd_data c=%0d: a=%h d=%h be=%h ifr=%h lsr=%h want %h %h %h %h %h",
                         c, mem_addr, mem_wdata, mem_be, if_rdata, ls_rdata,
                         e_addr, e_wdata, e_be, e_ifr, e_lsr);
            end
            case (phase)
                0: begin
                    if (w_if || w_ls) begin
                        phase = 1; own_ls = w_ls; last_ls = w_ls; m_we = w_ls && ls_w;
                        e_addr = w_ls ? ls_a : if_a;
                        e_wdata = w_ls ? ls_d : 32'h0;
                        e_be = w_ls ? ls_b : 4'hF;
                        busy_n = 0;
                        ack_at = ($urandom_range(0, 9) == 0) ? 99 : int'($urandom_range(0, 3));
                        if (w_ls) ls_pend = 0;
                        else if_pend = 0;
                    end
                end
                1: begin
                    busy_n++;
                    if (mem_ack) begin
                        if (!m_we) begin
                            if (own_ls) e_lsr = mem_rdata;
                            else e_ifr = mem_rdata;
                        end
                        m_err = 0; phase = 2;
                    end else if (TO != 0 && busy_n == TO) begin
                        if (!m_we) begin
                            if (own_ls) e_lsr = 32'h0;
                            else e_ifr = 32'h0;
                        end
                        m_err = 1; phase = 2;
                    end
                end
                default: begin
                    phase = 0; m_err = 0; done_cnt++;
                end
            endcase
        end
        checks++;
        if (done_cnt < 100) begin
            errors++; $display("FAIL rnd_progress: completions=%0d want >= 100", done_cnt);
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_fetch_zero_wait();
        test_store_wait();
        test_contention();
        test_timeout();
        test_collision();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1);
    end

endmodule
